pipe_stage_reg: RTL

Parametrised, elastic pipeline stage register for the five-stage MIPS core. It is the successor to the fixed IR/PC4/PC8/ALUResult/RD inter-stage latches. It carries NUM_CH channels of DATA_W bits between any two stages. It adds a valid/ready handshake, a two-entry skid buffer so stalls never drop data, a synchronous flush that inserts a NOP bubble, and a saturating stall-cycle counter for performance checks.

---
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register for the MIPS pipeline: NUM_CH channels of DATA_W bits,
// two-entry skid buffer, synchronous flush to a NOP bubble and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic                     flush,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [1:0]               dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and in_ready is a function of registered state only.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [NUM_CH*DATA_W-1:0]   main_q, main_d;
  logic [NUM_CH*DATA_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       accept, pop;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // An empty slot presents all zeros, which decodes as sll $0,$0,0.
  assign out_data  = out_valid ? main_q : '0;
  assign stall_cnt = cnt_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // The skid entry is older than anything upstream, so it moves up on pop.
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
